// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - DSO acquisition sequencer around the circular capture buffer (optional AUTO_TRIG_EN auto-trigger)
module capture_sequencer #(
    parameter int DEPTH = 6
`ifdef AUTO_TRIG_EN
    , parameter int DEL_W = 24
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic             continuous,
    input  logic [DEPTH-1:0] pre_len,
    input  logic             sample_en,
    input  logic             trig_in,
`ifdef AUTO_TRIG_EN
    input  logic [DEL_W-1:0] auto_timeout,
    output logic             forced,
`endif
    output logic [DEPTH-1:0] wr_addr,
    output logic             wr_en,
    output logic [DEPTH-1:0] trig_addr,
    output logic [DEPTH-1:0] rd_addr,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             rd_last,
    input  logic             rd_req,
    output logic             waiting_for_trigger,
    output logic             triggered,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE, PRE_FILL, ARMED, POST, DONE, READOUT
    } state_t;

    state_t           state, state_n;
    logic [DEPTH-1:0] pl;
    logic [DEPTH-1:0] fill_cnt;
    logic [DEPTH-1:0] post_cnt;
    logic [DEPTH-1:0] rd_cnt;
    logic             force_now;
    logic             trig_hit;
    logic             rd_fire;

`ifdef AUTO_TRIG_EN
    logic [DEL_W-1:0] to_cnt;
    // Forced trigger fires on the strobe that brings the ARMED strobe count up to the timeout
    assign force_now = (state == ARMED) && sample_en && (auto_timeout != '0)
                       && ((to_cnt + DEL_W'(1)) == auto_timeout);
`else
    assign force_now = 1'b0;
`endif

    assign trig_hit = (state == ARMED) && sample_en && (trig_in || force_now);
    assign rd_fire  = rd_valid && rd_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state and status/strobe outputs
    always_comb begin
        state_n             = state;
        wr_en               = 1'b0;
        rd_valid            = 1'b0;
        rd_last             = 1'b0;
        waiting_for_trigger = 1'b0;
        triggered           = 1'b0;
        done                = 1'b0;
        case (state)
            IDLE: begin
                if (arm) state_n = (pre_len == '0) ? ARMED : PRE_FILL;
            end
            PRE_FILL: begin
                wr_en = sample_en;
                if (sample_en && (fill_cnt == pl - DEPTH'(1))) state_n = ARMED;
            end
            ARMED: begin
                wr_en               = sample_en;
                waiting_for_trigger = 1'b1;
                if (trig_hit) state_n = POST;
            end
            POST: begin
                triggered = 1'b1;
                wr_en     = sample_en && (post_cnt != '0);
                if (post_cnt == '0)                          state_n = DONE;
                else if (sample_en && (post_cnt == DEPTH'(1))) state_n = DONE;
            end
            DONE: begin
                triggered = 1'b1;
                done      = 1'b1;
                if (rd_req) state_n = READOUT;
            end
            READOUT: begin
                triggered = 1'b1;
                rd_valid  = 1'b1;
                rd_last   = &rd_cnt;
                if (rd_ready && (&rd_cnt)) begin
                    if (continuous) state_n = (pl == '0) ? ARMED : PRE_FILL;
                    else            state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    // Buffer addresses, window counters and trigger bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr   <= '0;
            trig_addr <= '0;
            rd_addr   <= '0;
            pl        <= '0;
            fill_cnt  <= '0;
            post_cnt  <= '0;
            rd_cnt    <= '0;
`ifdef AUTO_TRIG_EN
            forced    <= 1'b0;
`endif
        end else begin
            if (wr_en) wr_addr <= wr_addr + DEPTH'(1);
            if (abort) begin
`ifdef AUTO_TRIG_EN
                forced <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            pl       <= pre_len;
                            fill_cnt <= '0;
`ifdef AUTO_TRIG_EN
                            forced   <= 1'b0;
`endif
                        end
                    end
                    PRE_FILL: begin
                        if (sample_en) fill_cnt <= fill_cnt + DEPTH'(1);
                    end
                    ARMED: begin
                        if (trig_hit) begin
                            trig_addr <= wr_addr;
                            post_cnt  <= ~pl;           // N-1-pl
`ifdef AUTO_TRIG_EN
                            forced    <= force_now && !trig_in;
`endif
                        end
                    end
                    POST: begin
                        if (wr_en) post_cnt <= post_cnt - DEPTH'(1);
                    end
                    DONE: begin
                        if (rd_req) begin
                            rd_addr <= trig_addr - pl;  // oldest sample
                            rd_cnt  <= '0;
                        end
                    end
                    READOUT: begin
                        if (rd_fire) begin
                            rd_addr <= rd_addr + DEPTH'(1);
                            rd_cnt  <= rd_cnt + DEPTH'(1);
                            if ((&rd_cnt) && continuous) begin
                                fill_cnt <= '0;
`ifdef AUTO_TRIG_EN
                                forced   <= 1'b0;
`endif
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef AUTO_TRIG_EN
    // Timeout counter: cleared outside ARMED, counts strobes while waiting for trigger
    always_ff @(posedge clk) begin
        if (rst || state != ARMED) to_cnt <= '0;
        else if (sample_en)        to_cnt <= to_cnt + DEL_W'(1);
    end
`endif

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - scoreboard testbench for capture_sequencer
module tb_capture_sequencer;

    logic       clk = 1'b0;
    logic       rst, arm, abort, continuous, sample_en, trig_in, rd_ready, rd_req;
    logic [5:0] pre_len;
    logic [5:0] wr_addr, trig_addr, rd_addr;
    logic       wr_en, rd_valid, rd_last, waiting_for_trigger, triggered, done;
`ifdef AUTO_TRIG_EN
    logic [23:0] auto_timeout;
    logic        forced;
`endif

    typedef struct {
        int addr;
        bit last;
    } rd_exp_t;

    rd_exp_t rq[$];
    int      n_checks = 0;
    int      n_errors = 0;
    int      exp_wa   = 0;
    int      nwr      = 0;
    int      nrd      = 0;

    capture_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .arm                 (arm),
        .abort               (abort),
        .continuous          (continuous),
        .pre_len             (pre_len),
        .sample_en           (sample_en),
        .trig_in             (trig_in),
`ifdef AUTO_TRIG_EN
        .auto_timeout        (auto_timeout),
        .forced              (forced),
`endif
        .wr_addr             (wr_addr),
        .wr_en               (wr_en),
        .trig_addr           (trig_addr),
        .rd_addr             (rd_addr),
        .rd_valid            (rd_valid),
        .rd_ready            (rd_ready),
        .rd_last             (rd_last),
        .rd_req              (rd_req),
        .waiting_for_trigger (waiting_for_trigger),
        .triggered           (triggered),
        .done                (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    // Write stream and readout scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (wr_en) begin
            check("wr_addr", wr_addr, exp_wa);
            exp_wa = (exp_wa + 1) % 64;
            nwr++;
        end
        if (rd_valid && rd_ready) begin
            if (rq.size() == 0) check("rd_unexpected", 1, 0);
            else begin
                rd_exp_t e;
                e = rq.pop_front();
                check("rd_addr", rd_addr, e.addr);
                check("rd_last", rd_last, e.last);
            end
            nrd++;
        end
    end

    task automatic step(input logic se, input logic tr);
        sample_en = se;
        trig_in   = tr;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        trig_in   = 1'b0;
    endtask

    task automatic strobe(input logic tr);
        step(1'b1, tr);
        repeat (3) step(1'b0, 1'b0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_wait"}, waiting_for_trigger, 0);
        check({tag, "_trig"}, triggered, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rdv"}, rd_valid, 0);
        check({tag, "_wren"}, wr_en, 0);
    endtask

    // Runs one acquisition; trigger lands on strobe trig_n counted from the (re)arm
    task automatic acquire(input int pre, input int trig_n, input bit do_arm,
                           input bit use_trig, input bit noise, output int ta);
        int  wa0, w0, cyc, k, t0, p;
        bit  seen;
        logic se, tr;
        wa0 = exp_wa; w0 = nwr; cyc = 0; k = 0; t0 = 0; seen = 0;
        p = 63 - pre;
        if (do_arm) begin
            pre_len = 6'(pre);
            arm = 1'b1;
            step(1'b0, 1'b0);
            arm = 1'b0;
        end
        while (!done && cyc < 3000) begin
            se = (cyc % 4 == 0);
            tr = se ? (use_trig && (k + 1 == trig_n)) : (noise && (cyc % 4 == 2));
            step(se, tr);
            if (se) begin
                k++;
                if (k == trig_n) begin seen = 1; t0 = cyc; end
            end
            cyc++;
            if (!done) check("waiting", waiting_for_trigger, (k >= pre && !seen));
        end
        check("done_reached", done, 1);
        check("triggered", triggered, 1);
        ta = (wa0 + trig_n - 1) % 64;
        check("trig_addr", trig_addr, ta);
        check("n_writes", nwr - w0, trig_n + 63 - pre);
        check("post_latency", cyc - t0 - 1, (p == 0) ? 1 : 4 * p);
    endtask

    task automatic push_readout(input int pre, input int ta);
        int start;
        start = (ta - pre + 64) % 64;
        for (int i = 0; i < 64; i++) rq.push_back('{(start + i) % 64, (i == 63)});
    endtask

    task automatic readout(input int pre, input int ta, input bit alt);
        int  n0, budget;
        int  held;
        bit  stalled;
        push_readout(pre, ta);
        rd_req = 1'b1;
        step(1'b0, 1'b0);
        rd_req = 1'b0;
        check("rd_valid_start", rd_valid, 1);
        n0 = nrd; budget = 0;
        while (nrd - n0 < 64 && budget < 500) begin
            rd_ready = alt ? ~rd_ready : 1'b1;
            stalled  = rd_valid && !rd_ready;
            held     = rd_addr;
            step(1'b0, 1'b0);
            if (stalled) check("rd_hold", rd_addr, held);
            budget++;
        end
        rd_ready = 1'b0;
        check("rd_transfers", nrd - n0, 64);
        check("rd_queue_empty", rq.size(), 0);
    endtask

    initial begin
        int ta, n0;
        rst = 1'b1; arm = 1'b0; abort = 1'b0; continuous = 1'b0; sample_en = 1'b0;
        trig_in = 1'b0; rd_ready = 1'b0; rd_req = 1'b0; pre_len = '0;
`ifdef AUTO_TRIG_EN
        auto_timeout = '0;
`endif
        repeat (2) step(1'b0, 1'b0);
        rst = 1'b0;
        check("rst_wr_addr", wr_addr, 0);
        check("rst_trig_addr", trig_addr, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rd_last", rd_last, 0);
        check_idle("rst");

        // pre 16, trigger on 30th sample, stray trig_in pulses, 50% rd_ready
        acquire(16, 30, 1, 1, 1, ta);
        check("t1_trig_addr", trig_addr, 29);
        readout(16, ta, 1);
        check_idle("t1_end");

        // pre 0, trigger on first strobe; arm in DONE is ignored
        acquire(0, 1, 1, 1, 0, ta);
        arm = 1'b1; step(1'b0, 1'b0); arm = 1'b0;
        check("done_ignores_arm", done, 1);
        readout(0, ta, 0);
        check_idle("t2_end");

        // pre 63: POST writes nothing
        acquire(63, 64, 1, 1, 0, ta);
        readout(63, ta, 1);

        // reset in the middle of POST
        pre_len = 6'd4; arm = 1'b1; step(1'b0, 1'b0); arm = 1'b0;
        for (int i = 1; i <= 7; i++) strobe(i == 5);
        check("mid_post_trig", triggered, 1);
        check("mid_post_done", done, 0);
        rst = 1'b1; step(1'b0, 1'b0); rst = 1'b0;
        exp_wa = 0;
        check("rst_post_wr_addr", wr_addr, 0);
        check("rst_post_trig_addr", trig_addr, 0);
        check_idle("rst_post");
        acquire(8, 12, 1, 1, 0, ta);
        readout(8, ta, 0);

        // abort in the middle of READOUT
        acquire(5, 7, 1, 1, 0, ta);
        push_readout(5, ta);
        rd_req = 1'b1; step(1'b0, 1'b0); rd_req = 1'b0;
        n0 = nrd;
        rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        rd_ready = 1'b0;
        check("abort_partial", nrd - n0, 10);
        abort = 1'b1; step(1'b0, 1'b0); abort = 1'b0;
        check_idle("abort");
        check("abort_rd_last", rd_last, 0);
        check("abort_wr_addr_kept", wr_addr, exp_wa);
        rq.delete();
        acquire(5, 6, 1, 1, 0, ta);
        readout(5, ta, 1);

        // continuous re-arm
        continuous = 1'b1;
        acquire(10, 12, 1, 1, 0, ta);
        readout(10, ta, 0);
        check("cont_prefill_wait", waiting_for_trigger, 0);
        check("cont_prefill_trig", triggered, 0);
        check("cont_prefill_rdv", rd_valid, 0);
        continuous = 1'b0;
        acquire(10, 13, 0, 1, 0, ta);
        readout(10, ta, 1);
        check_idle("cont_end");

`ifdef AUTO_TRIG_EN
        auto_timeout = 24'd10;
        acquire(0, 10, 1, 0, 0, ta);
        check("auto_forced", forced, 1);
        readout(0, ta, 0);
        acquire(0, 10, 1, 1, 0, ta);
        check("auto_real_wins", forced, 0);
        readout(0, ta, 1);
        auto_timeout = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
